regfile_frame_stack: RTL
========================

// Module: regfile_frame_stack
// PURPOSE
//  Parametrised register file with a hardware frame stack for procedure call/return.
//  backup spills every register plus the return address (RA) into the next stack frame;
//  restore reloads the most recent frame. Spill/fill is sequential (one register per
//  cycle) with a busy handshake. Sits in the datapath data-management block, feeding
//  ALU operands A/B; successor to the fixed 16x16, unchecked backup/restore scheme.
// PARAMETERS
//  WIDTH  16  data width of registers and RA
//  NREGS  16  registers; r0 reads zero and is never written, saved or restored
//  DEPTH  4   frames held in the stack
//  AW     $clog2(NREGS) (derived; not overridden)
//  LW     $clog2(DEPTH+1) (derived; not overridden)
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      synchronous, active-high reset
//  we       in   1      register write enable
//  waddr    in   AW     write index
//  wdata    in   WIDTH  write data
//  raddr_a  in   AW     read index, port A
//  raddr_b  in   AW     read index, port B
//  rdata_a  out  WIDTH  combinational read, port A (r0 -> 0)
//  rdata_b  out  WIDTH  combinational read, port B (r0 -> 0)
//  backup   in   1      request frame push (single-cycle sample)
//  restore  in   1      request frame pop (single-cycle sample)
//  ra_in    in   WIDTH  RA captured with the frame on backup accept
//  ra_out   out  WIDTH  registered RA from last restored frame
//  busy     out  1      spill/fill in progress
//  level    out  LW     frames currently stored
//  full     out  1      level == DEPTH
//  empty    out  1      level == 0
//  ovf_err  out  1      1-cycle pulse: backup while full
//  unf_err  out  1      1-cycle pulse: restore while empty
// BEHAVIOUR
//  Reset: regfile all 0, ra_out=0, busy=0, level=0, ovf_err=unf_err=0, state IDLE.
//   Frame memory not cleared. Reset mid SAVE/LOAD aborts; partial frame discarded.
//  FSM IDLE/SAVE/LOAD. Requests sampled only in IDLE; ignored (no error) when busy.
//  backup & restore both high in IDLE: no-op, no error pulse.
//  backup accept (IDLE, !full, cycle T): frame[level].ra<=ra_in; level<=level+1; -> SAVE.
//   we on cycle T commits first; its value is what gets saved.
//  SAVE: cycle T+k (k=1..NREGS-1) copies r[k] to frame slot k; -> IDLE after r[NREGS-1].
//  restore accept (IDLE, !empty, cycle T): level<=level-1; ra_out<=frame[level-1].ra;
//   -> LOAD; cycle T+k writes frame slot k back to r[k]; -> IDLE after r[NREGS-1].
//   we on cycle T commits, then is overwritten by the fill.
//  busy=1 exactly cycles T+1..T+NREGS-1; new requests accepted from T+NREGS.
//  we ignored while busy; reads stay live (return partially filled state; caller stalls).
//  backup while full / restore while empty: matching err pulse next cycle; no other change.
//  we with waddr=0: ignored. level, full, empty registered, consistent every cycle.
// CONFIGURATION
//  REGSTACK_CLEAR_EN defined: in SAVE each r[k] zeroed in the same cycle it is copied,
//   so callee starts with a clean file (r1..r(NREGS-1)=0 when busy drops).
//  Not defined: SAVE leaves register contents unchanged.
// TESTING
//  Fill: write r1..r15=1..15, ra_in=50, backup -> busy high 15 cycles, level=1, regs unchanged.
//  Nest 3: pushes with r[k]=k+16*n, ra_in=50,51,52; 3 restores -> ra_out 52,51,50, all
//   r[k] match each frame, level 3->0, empty=1.
//  Overflow: 4 pushes, 5th backup -> ovf_err 1 cycle, level=4, busy stays 0.
//  Underflow: restore after reset -> unf_err 1 cycle, ra_out=0, level=0.
//  Hazards: we r3=0xAAAA on backup cycle -> saved value 0xAAAA; we during SAVE ignored;
//   backup+restore same cycle -> no-op; reset at SAVE cycle 5 -> level=0, regs=0, busy=0.
//  REGSTACK_CLEAR_EN build: after backup r1..r15=0; restore returns original 1..15.

Source files
------------

// File: rtl/regfile_frame_stack.sv
// Register file with a DEPTH-frame call stack: combinational reads, spill/fill one register per cycle,
// busy for NREGS-1 cycles with new requests ignored meanwhile; define REGSTACK_CLEAR_EN to zero registers as they are spilled.
module regfile_frame_stack #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(NREGS),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             backup,
    input  logic             restore,
    input  logic [WIDTH-1:0] ra_in,
    output logic [WIDTH-1:0] ra_out,
    output logic             busy,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_LOAD} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [FW-1:0]      frm_q, frm_d;
    logic [LW-1:0]      level_q, level_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [WIDTH-1:0]   ra_out_q, ra_out_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];

    // Frame storage has no reset; a frame is only visible once level covers it.
    logic [WIDTH-1:0]   frame_q    [DEPTH][NREGS];
    logic [WIDTH-1:0]   frame_ra_q [DEPTH];

    logic               ra_we;
    logic               save_we;
    logic [FW-1:0]      push_idx;
    logic [FW-1:0]      pop_idx;

    assign push_idx = level_q[FW-1:0];
    assign pop_idx  = FW'(level_q - LW'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frm_d    = frm_q;
        level_d  = level_q;
        ra_out_d = ra_out_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        ra_we    = 1'b0;
        save_we  = 1'b0;
        regs_d   = regs_q;

        // A write in the accept cycle lands before the first spill/fill step.
        if (we && (state_q == ST_IDLE) && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (backup && !restore) begin
                    if (full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        ra_we   = 1'b1;
                        frm_d   = push_idx;
                        level_d = level_q + LW'(1);
                        cnt_d   = AW'(1);
                        state_d = ST_SAVE;
                    end
                end else if (restore && !backup) begin
                    if (empty_q) begin
                        unf_d = 1'b1;
                    end else begin
                        frm_d    = pop_idx;
                        level_d  = level_q - LW'(1);
                        ra_out_d = frame_ra_q[pop_idx];
                        cnt_d    = AW'(1);
                        state_d  = ST_LOAD;
                    end
                end
            end
            ST_SAVE: begin
                save_we = 1'b1;
`ifdef REGSTACK_CLEAR_EN
                regs_d[cnt_q] = '0;
`endif
                if (cnt_q == LAST_REG) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_LOAD: begin
                regs_d[cnt_q] = frame_q[frm_q][cnt_q];
                if (cnt_q == LAST_REG) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        regs_d[0] = '0;
        full_d    = (level_d == LW'(DEPTH));
        empty_d   = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            frm_q    <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ra_out_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frm_q    <= frm_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ra_out_q <= ra_out_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            regs_q   <= regs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ra_we) begin
            frame_ra_q[push_idx] <= ra_in;
        end
        if (save_we) begin
            frame_q[frm_q][cnt_q] <= regs_q[cnt_q];
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
    assign ra_out  = ra_out_q;
    assign busy    = (state_q != ST_IDLE);
    assign level   = level_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule
